dmem_arbiter: RTL
=================

// Module: dmem_arbiter
// PURPOSE
//  Two-requester round-robin arbiter in front of the shared 256-word DataMem.
//  Port m0 = CPU load/store; port m1 = DMA/UART peripheral master.
//  Grants at most one access per clk and drives the single DataMem rd/wr port.
//  Returns registered read data and an error flag for bad addresses.
// PARAMETERS
//  DATA_W        32   data width of requester and memory ports
//  ADDR_W        32   byte-address width
//  RAM_SIZE      256  DataMem depth in words
//  RAM_SIZE_BIT  8    log2(RAM_SIZE); word index = addr[RAM_SIZE_BIT+1:2]
//  LOCK_MAX      16   max cycles a lock may be held (DMEM_ARB_LOCK_EN only)
// PORTS
//  clk         in   1       system clock, all state on posedge
//  reset       in   1       synchronous, active-high
//  m0_req      in   1       m0 access request; held until m0_gnt
//  m0_wr       in   1       1=write, 0=read; stable while m0_req
//  m0_addr     in   ADDR_W  byte address; stable while m0_req
//  m0_wdata    in   DATA_W  write data
//  m0_gnt      out  1       comb.: m0 access performed this cycle
//  m0_rvalid   out  1       reg.: response for last m0 grant
//  m0_rdata    out  DATA_W  reg.: read data (0 for writes/errors)
//  m0_err      out  1       reg.: last m0 grant had bad address
//  m1_*        --   --      identical set for requester m1
//  m0_lock/m1_lock in 1     lock request (DMEM_ARB_LOCK_EN only)
//  mem_rd      out  1       to DataMem rd
//  mem_wr      out  1       to DataMem wr
//  mem_addr    out  ADDR_W  to DataMem addr (granted address)
//  mem_wdata   out  DATA_W  to DataMem wdata
//  mem_rdata   in   DATA_W  from DataMem rdata (combinational)
// BEHAVIOUR
//  - Reset (sync): rr_last<=1 (m0 wins first tie), state<=IDLE, lock_cnt<=0,
//    all rvalid/err/rdata<=0. While reset=1: gnt=0, mem_rd=0, mem_wr=0.
//  - Grant (comb.): one requester -> granted. Both -> the one != rr_last.
//    On grant, rr_last<=granted index. No req -> mem_rd=mem_wr=0, mem_addr=0.
//  - Bad address: addr[1:0]!=0 or addr[ADDR_W-1:RAM_SIZE_BIT+2]!=0.
//    Still granted (consumed), mem_rd/mem_wr forced 0; next cycle
//    rvalid=1, err=1, rdata=0.
//  - Good access: mem_rd=~wr, mem_wr=wr in grant cycle (write lands at that
//    posedge); next cycle rvalid=1, err=0, rdata=mem_rdata (read) or 0 (write).
//  - Latency: gnt same cycle as req; response exactly 1 cycle after gnt.
//    rvalid is a 1-cycle pulse; back-to-back grants give back-to-back rvalid.
//  - Requester changing addr/wr before gnt: undefined; bench flags it.
//  - States: IDLE (normal RR) and LOCK0/LOCK1 (lock feature only).
// CONFIGURATION
//  DMEM_ARB_LOCK_EN defined: grant with mN_lock=1 moves IDLE->LOCKn; in LOCKn
//    only mN is granted, lock_cnt increments per cycle. Exit to IDLE on a
//    granted mN access with mN_lock=0, on mN_req=0, or at lock_cnt==LOCK_MAX-1
//    (forced release; rr_last=n so the other port wins next tie).
//  Not defined: lock ports absent; state stays IDLE; plain RR only.
// STRUCTURE
//  dmem_arb_pkg (shared constants): state encodings IDLE/LOCK0/LOCK1,
//    port indices M0=0/M1=1, addr-check field positions.
//  Sub-module dmem_rr_pick: 2-way RR picker (req[1:0], last -> gnt[1:0]).
//  Top: picker, address check, mux to mem_*, response regs, lock FSM.
// TESTING
//  1. m0 write 0x0000_0010 data 0xDEADBEEF, then read 0x10 -> m0_gnt same
//     cycle, m0_rvalid next cycle, m0_rdata=0xDEADBEEF, m0_err=0.
//  2. m0,m1 req every cycle (reads 0x0, 0x4) -> grants alternate m0,m1,m0,...
//     starting with m0 after reset; never both gnt.
//  3. m1 write addr 0x0000_0402 (misaligned) and 0x0000_0400 (out of range) ->
//     m1_gnt=1, mem_wr=0, next cycle m1_err=1, rdata=0; RAM unchanged.
//  4. Reset asserted for 1 cycle while m0 write pending -> mem_wr=0 that
//     cycle, rvalid=0 after; next tie grants m0.
//  5. LOCK_EN: m0 lock for 3 accesses with m1 requesting -> m1 stalls 3
//     cycles, then granted; lock held >LOCK_MAX cycles -> forced release.
//  6. Random m0/m1 traffic vs reference model -> rdata matches; no starvation
//     >2 cycles (lock off).

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared constants for the DataMem arbiter: lock FSM encodings, requester
// indices and the byte-offset width used by the address check.
package dmem_arb_pkg;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_LOCK0 = 2'b01;
  localparam logic [1:0] ST_LOCK1 = 2'b10;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  // Byte-offset bits below the word index; a word access needs them zero.
  localparam int WORD_LSB = 2;

endpackage

// File: rtl/dmem_rr_pick.sv
// Two-way round-robin picker: on a tie the requester that was not granted
// last wins. Purely combinational, no backpressure of its own.
module dmem_rr_pick
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) begin
      gnt_o = (last_i == M1) ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter for the shared DataMem port; grant same cycle, response 1 cycle later.
// Losers simply hold req; optional bus lock enabled by DMEM_ARB_LOCK_EN.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 32,
  parameter int RAM_SIZE     = 256,
  parameter int RAM_SIZE_BIT = 8,
  parameter int LOCK_MAX     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_wr,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_wr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_err,
`ifdef DMEM_ARB_LOCK_EN
  input  logic              m0_lock,
  input  logic              m1_lock,
`endif
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = (LOCK_MAX > 2) ? $clog2(LOCK_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);

  logic lock0_w, lock1_w;
`ifdef DMEM_ARB_LOCK_EN
  assign lock0_w = m0_lock;
  assign lock1_w = m1_lock;
`else
  assign lock0_w = 1'b0;
  assign lock1_w = 1'b0;
`endif

  logic [1:0]              state_q, state_d;
  logic [CNT_W-1:0]        lock_cnt_q, lock_cnt_d;
  logic                    rr_last_q, rr_last_d;
  logic                    m0_rvalid_q, m1_rvalid_q, m0_err_q, m1_err_q;
  logic [DATA_W-1:0]       m0_rdata_q, m1_rdata_q;

  logic [1:0]              eff_req, pick_gnt, gnt;
  logic                    any_gnt, sel_wr, bad;
  logic [ADDR_W-1:0]       sel_addr;
  logic [DATA_W-1:0]       sel_wdata;
  logic [RAM_SIZE_BIT-1:0] word_idx;
  logic                    own_idx, own_req, own_lock;

  // A lock owner hides the other requester from the picker.
  always_comb begin
    eff_req = {m1_req, m0_req};
    if (state_q == ST_LOCK0) eff_req = {1'b0, m0_req};
    if (state_q == ST_LOCK1) eff_req = {m1_req, 1'b0};
  end

  dmem_rr_pick u_pick (
    .req_i  (eff_req),
    .last_i (rr_last_q),
    .gnt_o  (pick_gnt)
  );

  assign gnt       = reset ? 2'b00 : pick_gnt;
  assign any_gnt   = |gnt;
  assign m0_gnt    = gnt[M0];
  assign m1_gnt    = gnt[M1];
  assign sel_addr  = gnt[M1] ? m1_addr  : m0_addr;
  assign sel_wr    = gnt[M1] ? m1_wr    : m0_wr;
  assign sel_wdata = gnt[M1] ? m1_wdata : m0_wdata;

  // The depth compare also covers a RAM that is not a full power of two.
  assign word_idx = sel_addr[RAM_SIZE_BIT+WORD_LSB-1:WORD_LSB];
  assign bad      = (|sel_addr[WORD_LSB-1:0])
                 || (|sel_addr[ADDR_W-1:RAM_SIZE_BIT+WORD_LSB])
                 || (int'(word_idx) >= RAM_SIZE);

  assign mem_rd    = any_gnt && !bad && !sel_wr;
  assign mem_wr    = any_gnt && !bad && sel_wr;
  assign mem_addr  = any_gnt ? sel_addr  : '0;
  assign mem_wdata = any_gnt ? sel_wdata : '0;

  assign own_idx  = (state_q == ST_LOCK1);
  assign own_req  = own_idx ? m1_req  : m0_req;
  assign own_lock = own_idx ? lock1_w : lock0_w;

  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    rr_last_d  = any_gnt ? gnt[M1] : rr_last_q;
    case (state_q)
      ST_LOCK0, ST_LOCK1: begin
        lock_cnt_d = lock_cnt_q + 1'b1;
        // Leaving the lock leaves the owner as last, so the other side wins the next tie.
        if ((gnt[own_idx] && !own_lock) || !own_req || (lock_cnt_q == CNT_LAST)) begin
          state_d    = ST_IDLE;
          lock_cnt_d = '0;
          rr_last_d  = own_idx;
        end
      end
      default: begin
        if (gnt[M0] && lock0_w) begin
          state_d = ST_LOCK0;
        end else if (gnt[M1] && lock1_w) begin
          state_d = ST_LOCK1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      lock_cnt_q  <= '0;
      rr_last_q   <= M1;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_err_q    <= 1'b0;
      m1_err_q    <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      lock_cnt_q  <= lock_cnt_d;
      rr_last_q   <= rr_last_d;
      m0_rvalid_q <= gnt[M0];
      m1_rvalid_q <= gnt[M1];
      m0_err_q    <= gnt[M0] && bad;
      m1_err_q    <= gnt[M1] && bad;
      m0_rdata_q  <= (gnt[M0] && mem_rd) ? mem_rdata : '0;
      m1_rdata_q  <= (gnt[M1] && mem_rd) ? mem_rdata : '0;
    end
  end

  assign m0_rvalid = m0_rvalid_q;
  assign m1_rvalid = m1_rvalid_q;
  assign m0_err    = m0_err_q;
  assign m1_err    = m1_err_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;

endmodule
